// File: rtl/cordic_freq_avg.sv
// Instantaneous-frequency and magnitude averager for a rectangular-to-polar CORDIC.
// Averages the wrapped phase step and clamped magnitude over 2^log_navg samples.
module cordic_freq_avg #(
    parameter int width    = 18,
    parameter int log_navg = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [width-1:0]   mag_in,
    input  logic [width:0]     phase_in,
    input  logic               clr,
    output logic               out_valid,
    output logic [width:0]     freq_out,
    output logic [width-1:0]   mag_out,
    output logic               primed
);

    localparam int FW = width + 1 + log_navg;
    localparam int MW = width + log_navg;

    typedef enum logic {EMPTY, RUN} state_t;

    state_t                state, state_nxt;
    logic [log_navg-1:0]   count;
    logic [width:0]        p_prev;
    logic signed [FW-1:0]  facc;
    logic [MW-1:0]         macc;

    logic                  take;
    logic                  last;
    logic signed [width:0] diff;
    logic [width-1:0]      mag_clamped;
    logic signed [FW-1:0]  fsum;
    logic signed [FW-1:0]  favg;
    logic [MW-1:0]         msum;
    logic [MW-1:0]         mavg;

    assign take = in_valid && !clr;
    assign last = (state == RUN) && take && (count == '1);

    // Modular subtraction on the phase circle gives the wrapped step for free.
    assign diff        = $signed(phase_in - p_prev);
    assign mag_clamped = mag_in[width-1] ? '0 : mag_in;
    assign fsum        = facc + {{log_navg{diff[width]}}, diff};
    assign msum        = macc + {{log_navg{1'b0}}, mag_clamped};
    assign favg        = fsum >>> log_navg;
    assign mavg        = msum >> log_navg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = EMPTY;
        else if (in_valid && state == EMPTY)
            state_nxt = RUN;
    end

    always_comb begin
        primed = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            freq_out  <= '0;
            mag_out   <= '0;
            count     <= '0;
            p_prev    <= '0;
            facc      <= '0;
            macc      <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                count <= '0;
                facc  <= '0;
                macc  <= '0;
            end else if (take) begin
                p_prev <= phase_in;
                if (state == EMPTY) begin
                    // First sample only establishes the phase reference.
                    count <= '0;
                    facc  <= '0;
                    macc  <= '0;
                end else if (last) begin
                    freq_out  <= favg[width:0];
                    mag_out   <= mavg[width-1:0];
                    out_valid <= 1'b1;
                    count     <= '0;
                    facc      <= '0;
                    macc      <= '0;
                end else begin
                    facc  <= fsum;
                    macc  <= msum;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_freq_avg.sv
// Scoreboard bench for cordic_freq_avg: a behavioural model queues expected
// block averages as samples are driven; each clock the DUT pulse is matched.
module tb_cordic_freq_avg;

    localparam int W    = 18;
    localparam int L    = 4;
    localparam int N    = 16;
    localparam int MOD  = 524288;
    localparam int HALF = 262144;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] mag_in = '0;
    logic [W:0]   phase_in = '0;
    logic         out_valid;
    logic [W:0]   freq_out;
    logic [W-1:0] mag_out;
    logic         primed;

    cordic_freq_avg #(.width(W), .log_navg(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mag_in(mag_in),
        .phase_in(phase_in), .clr(clr), .out_valid(out_valid),
        .freq_out(freq_out), .mag_out(mag_out), .primed(primed)
    );

    always #5 clk = ~clk;

    typedef struct {int freq; int mag;} exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int pulses = 0;

    bit m_primed = 0;
    int m_cnt = 0, m_fs = 0, m_ms = 0, m_prev = 0;

    function automatic int wrapdiff(int a, int b);
        int d;
        d = (a - b) % MOD;
        if (d < 0) d += MOD;
        if (d >= HALF) d -= MOD;
        return d;
    endfunction

    function automatic int floordiv(int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic void model_reset();
        m_primed = 0; m_cnt = 0; m_fs = 0; m_ms = 0;
    endfunction

    // Advance one clock, then match any out_valid pulse against the queue.
    task automatic tick();
        exp_t e;
        int f;
        @(posedge clk);
        #1;
        if (out_valid) pulses++;
        if (out_valid && sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse freq=%0d mag=%0d", $signed(freq_out), mag_out);
        end else if (!out_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            total++; bad++;
            $display("FAIL missing_pulse got out_valid=0 want freq=%0d mag=%0d", e.freq, e.mag);
        end else if (out_valid) begin
            e = sbq.pop_front();
            f = $signed(freq_out);
            total++;
            if (f !== e.freq || int'(mag_out) !== e.mag) begin
                bad++;
                $display("FAIL block_avg got freq=%0d mag=%0d want freq=%0d mag=%0d",
                         f, mag_out, e.freq, e.mag);
            end
        end
    endtask

    task automatic drive(input int p, input int m, input bit v, input bit c);
        int pw, d;
        exp_t e;
        pw = ((p % MOD) + MOD) % MOD;
        in_valid = v; clr = c; phase_in = pw[W:0]; mag_in = m[W-1:0];
        if (c) model_reset();
        else if (v) begin
            if (!m_primed) begin
                m_primed = 1; m_prev = pw; m_cnt = 0;
            end else begin
                d = wrapdiff(pw, m_prev);
                m_prev = pw;
                m_fs += d;
                m_ms += (m < 0) ? 0 : m;
                m_cnt++;
                if (m_cnt == N) begin
                    e.freq = floordiv(m_fs);
                    e.mag  = m_ms / N;
                    sbq.push_back(e);
                    m_cnt = 0; m_fs = 0; m_ms = 0;
                end
            end
        end
        tick();
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic ramp(input int start, input int step, input int n, input int mag, input int gap);
        int p;
        p = start;
        for (int i = 0; i < n; i++) begin
            drive(p, mag, 1'b1, 1'b0);
            for (int g = 0; g < gap; g++) tick();
            p += step;
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got %0d queued want 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        #12;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_primed", primed, 1'b0);
        total++;
        if (freq_out !== '0 || mag_out !== '0) begin
            bad++;
            $display("FAIL rst_outputs got freq=%0d mag=%0d want 0 0", freq_out, mag_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        int p0;
        p0 = pulses;
        ramp(0, 53, 3 * N + 1, 1000, 0);
        check_bit("ramp_primed", primed, 1'b1);
        total++;
        if (pulses - p0 != 3) begin
            bad++;
            $display("FAIL ramp_pulses got %0d want 3", pulses - p0);
        end
        check_drained("ramp");
    endtask

    task automatic test_wrap();
        drive(0, 0, 1'b0, 1'b1);
        ramp(524000, 53, 2 * N + 1, 1000, 0);
        drive(0, 0, 1'b0, 1'b1);
        ramp(100, -100, 2 * N + 1, 500, 0);
        total++;
        if ($signed(freq_out) !== -100) begin
            bad++;
            $display("FAIL neg_ramp got %0d want -100", $signed(freq_out));
        end
        check_drained("wrap");
    endtask

    task automatic test_floor();
        int p;
        drive(0, 0, 1'b0, 1'b1);
        p = 0;
        drive(p, 777, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i % 2 == 1) p -= 1;
            drive(p, (i % 2 == 0) ? 200 : -5, 1'b1, 1'b0);
        end
        total++;
        if ($signed(freq_out) !== -1 || mag_out !== 18'd100) begin
            bad++;
            $display("FAIL floor_clamp got freq=%0d mag=%0d want -1 100", $signed(freq_out), mag_out);
        end
        check_drained("floor");
    endtask

    task automatic test_gaps();
        int p0;
        drive(0, 0, 1'b0, 1'b1);
        p0 = pulses;
        ramp(0, 53, 2 * N + 1, 1000, 2);
        total++;
        if (pulses - p0 != 2) begin
            bad++;
            $display("FAIL gap_pulses got %0d want 2", pulses - p0);
        end
        check_drained("gaps");
    endtask

    task automatic test_clr();
        int p0;
        drive(0, 0, 1'b0, 1'b1);
        ramp(0, 53, 10, 1000, 0);
        check_bit("clr_pre_primed", primed, 1'b1);
        drive(530, 1000, 1'b1, 1'b1);
        check_bit("clr_primed", primed, 1'b0);
        p0 = pulses;
        ramp(2000, 53, N, 1000, 0);
        total++;
        if (pulses != p0) begin
            bad++;
            $display("FAIL clr_early_pulse got %0d want 0", pulses - p0);
        end
        ramp(2000 + 53 * N, 53, 1, 1000, 0);
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL clr_pulses got %0d want 1", pulses - p0);
        end
        check_drained("clr");
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1'b0, 1'b1);
        ramp(0, 53, 5, 1000, 0);
        total++;
        if ($signed(freq_out) !== 53) begin
            bad++;
            $display("FAIL pre_reset_freq got %0d want 53", $signed(freq_out));
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_bit("arst_out_valid", out_valid, 1'b0);
        check_bit("arst_primed", primed, 1'b0);
        total++;
        if (freq_out !== '0 || mag_out !== '0) begin
            bad++;
            $display("FAIL arst_outputs got freq=%0d mag=%0d want 0 0", freq_out, mag_out);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ramp(0, 53, 2 * N + 1, 1000, 0);
        total++;
        if ($signed(freq_out) !== 53 || mag_out !== 18'd1000) begin
            bad++;
            $display("FAIL arst_recover got freq=%0d mag=%0d want 53 1000", $signed(freq_out), mag_out);
        end
        check_drained("arst");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_wrap();
        test_floor();
        test_gaps();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
